// File: rtl/jedro_1_dmem_resp_pkg.sv
// Shared definitions for the jedro_1 data-memory responder.
package jedro_1_dmem_resp_pkg;

  localparam int          DMEM_BE_WIDTH       = 4;
  localparam logic [31:0] DMEM_DATA_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_resp_state_e;

  // Request fields held from accept until the response cycle.
  typedef struct packed {
    logic                     we;
    logic [DMEM_BE_WIDTH-1:0] be;
    logic [31:0]              wdata;
    logic                     err;
  } dmem_req_t;

  // Replace the byte lanes selected by be with the lanes of nw.
  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] nw,
                                           input logic [DMEM_BE_WIDTH-1:0] be);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < DMEM_BE_WIDTH; n++) begin
      if (be[n]) r[8*n +: 8] = nw[8*n +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/jedro_1_dmem_resp_array.sv
// Word storage for the data-memory responder: byte-enabled write,
// registered read. A read issued in the same cycle as a write to the
// same word sees the new data, so a read accepted during the RESP of a
// write returns what that write stored.
module jedro_1_dmem_array
  import jedro_1_dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [DMEM_BE_WIDTH-1:0] be_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic                     rclr_i,
  input  logic [AW-1:0]            raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word;

  // Read word with write-first forwarding for a same-word write.
  always_comb begin
    rd_word = mem[raddr_i];
    if (we_i && (waddr_i == raddr_i)) rd_word = be_merge(rd_word, wdata_i, be_i);
  end

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int n = 0; n < DMEM_BE_WIDTH; n++) begin
        if (be_i[n]) mem[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
  end

  // Read register: loads the word, or zero for write/error responses, and
  // holds its value when no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i)       rdata_o <= '0;
    else if (re_i)   rdata_o <= rclr_i ? 32'h0 : rd_word;
  end

endmodule

// File: rtl/jedro_1_dmem_resp.sv
// Data-memory responder: target side of the LSU req/gnt/rvalid bus.
// One transaction in flight; the response appears WAIT_CYCLES+1 cycles
// after accept, and a new request may be accepted in the response cycle.
module jedro_1_dmem_resp
  import jedro_1_dmem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_DATA_BASE_ADDR,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [DMEM_BE_WIDTH-1:0] be_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [32:0]   SPAN      = 33'(4 * DEPTH_WORDS);

  dmem_resp_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q;
  dmem_req_t        req_q;
  logic [AW-1:0]    idx_q;

  logic          accept;
  logic [32:0]   off;
  logic          acc_err;
  logic [AW-1:0] idx_in;

  logic          rd_en, rd_clr, wr_en;
  logic [AW-1:0] rd_idx;

  // Address decode of the incoming request. A byte address below the base
  // wraps the 33-bit offset negative, so one unsigned compare covers both ends.
  always_comb begin
    off     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    acc_err = (addr_i[1:0] != 2'b00) || off[32] || (off >= SPAN);
    idx_in  = off[AW+1:2];
  end

  // Grant and next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_o   = req_i && !rst_i && ((state_q == DMEM_IDLE) || (state_q == DMEM_RESP));
    accept  = gnt_o;
    case (state_q)
      DMEM_IDLE, DMEM_RESP: begin
        if (accept) state_d = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        else        state_d = DMEM_IDLE;
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) state_d = DMEM_RESP;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DMEM_IDLE;
    else       state_q <= state_d;
  end

  // Wait-state down-counter, loaded on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        cnt_q <= '0;
    else if (accept && (WAIT_CYCLES > 0))             cnt_q <= WAIT_LOAD;
    else if ((state_q == DMEM_WAIT) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
  end

  // Capture request fields on accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_q <= '{we: we_i, be: be_i, wdata: wdata_i, err: acc_err};
      idx_q <= idx_in;
    end
  end

  // The array read is issued the cycle before RESP so its registered data
  // lines up with rvalid_o: straight from the bus when there are no wait
  // states, otherwise from the held request in the last WAIT cycle.
  generate
    if (WAIT_CYCLES == 0) begin : g_rd_direct
      always_comb begin
        rd_en  = accept;
        rd_idx = idx_in;
        rd_clr = we_i || acc_err;
      end
    end else begin : g_rd_held
      always_comb begin
        rd_en  = (state_q == DMEM_WAIT) && (cnt_q == '0) && !rst_i;
        rd_idx = idx_q;
        rd_clr = req_q.we || req_q.err;
      end
    end
  endgenerate

  // Writes commit in the response cycle; a reset in that cycle drops it.
  always_comb begin
    wr_en = (state_q == DMEM_RESP) && req_q.we && !req_q.err && !rst_i;
  end

  // Registered response valid/error, set on entry to RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= (state_d == DMEM_RESP);
      if (state_d == DMEM_RESP) err_o <= (WAIT_CYCLES == 0) ? acc_err : req_q.err;
    end
  end

  jedro_1_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .be_i    (req_q.be),
    .waddr_i (idx_q),
    .wdata_i (req_q.wdata),
    .re_i    (rd_en),
    .rclr_i  (rd_clr),
    .raddr_i (rd_idx),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_jedro_1_dmem_resp.sv
// Bench for jedro_1_dmem_resp: three instances (0, 3 and 2 wait states),
// directed stimulus, expected responses queued at accept and matched on rvalid.
module tb_jedro_1_dmem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NI   = 3;
  localparam int          WC [NI] = '{0, 3, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [NI];
  logic        we    [NI];
  logic [3:0]  be    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        gnt   [NI];
  logic        rvalid[NI];
  logic [31:0] rdata [NI];
  logic        err   [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      jedro_1_dmem_resp #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 2))
      ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req[g]),
        .we_i     (we[g]),
        .be_i     (be[g]),
        .addr_i   (addr[g]),
        .wdata_i  (wdata[g]),
        .gnt_o    (gnt[g]),
        .rvalid_o (rvalid[g]),
        .rdata_o  (rdata[g]),
        .err_o    (err[g])
      );
    end
  endgenerate

  typedef struct {
    int          inst;
    int          due;
    logic        err;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          ntests = 0;
  int          nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: each rvalid must match the oldest pending entry of
  // that instance, in the cycle it is due.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rvalid[i] === 1'b1) begin
        int k;
        k = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].inst == i) begin
            k = j;
            break;
          end
        end
        if (k < 0) begin
          chk($sformatf("spurious_rvalid_i%0d", i), 32'd1, 32'd0);
        end else begin
          chk({sb[k].tag, "_cycle"}, cyc, sb[k].due);
          chk({sb[k].tag, "_err"}, {31'd0, err[i]}, {31'd0, sb[k].err});
          chk({sb[k].tag, "_rdata"}, rdata[i], sb[k].rdata);
          sb.delete(k);
        end
      end
    end
  end

  // Present a request and hold it until granted; on grant, record the
  // expected response. Leaves req high so callers can chain requests.
  task automatic issue(input int i, input string tag, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input bit drop,
                       output int waits);
    exp_t e;
    logic bad;
    int   key;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    waits = 0;
    forever begin
      @(negedge clk);
      if (gnt[i] === 1'b1) break;
      waits++;
      if (waits > 60) begin
        chk({tag, "_gnt_timeout"}, 32'd1, 32'd0);
        return;
      end
    end
    bad = (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'h1000);
    key = i * 4096 + int'((a - BASE) >> 2);
    e.inst = i; e.due = cyc + 1 + WC[i]; e.tag = tag;
    if (bad) begin
      e.err = 1'b1; e.rdata = 32'h0;
    end else if (w) begin
      logic [31:0] old;
      old = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int n = 0; n < 4; n++) if (b[n]) old[8*n +: 8] = d[8*n +: 8];
      if (!drop) mdl[key] = old;
      e.err = 1'b0; e.rdata = 32'h0;
    end else begin
      e.err = 1'b0; e.rdata = mdl[key];
    end
    if (!drop) sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = BASE; wdata[i] = 32'h0;
    end
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", {31'd0, gnt[0]}, 32'd0);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_rvalid_i%0d", i), {31'd0, rvalid[i]}, 32'd0);
      chk($sformatf("reset_err_i%0d", i), {31'd0, err[i]}, 32'd0);
      chk($sformatf("reset_rdata_i%0d", i), rdata[i], 32'd0);
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // zero wait states: full/byte writes, errors, bypass, boundaries
    issue(0, "w0_wr_full", 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, w);
    chk("w0_wr_full_gnt_wait", w, 0);
    idle(0); @(posedge clk); #1;
    issue(0, "w0_rd_full", 1'b0, 4'h0, 32'h8000_0010, 32'h0, 1'b0, w);
    issue(0, "w0_wr_byte", 1'b1, 4'b0010, 32'h8000_0010, 32'h0000_5A00, 1'b0, w);
    issue(0, "w0_rd_byte", 1'b0, 4'h0, 32'h8000_0010, 32'h0, 1'b0, w);
    issue(0, "w0_misalign", 1'b0, 4'h0, 32'h8000_0012, 32'h0, 1'b0, w);
    issue(0, "w0_below", 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, 1'b0, w);
    issue(0, "w0_above_wr", 1'b1, 4'hF, 32'h8000_1000, 32'hFFFF_FFFF, 1'b0, w);
    issue(0, "w0_be0_wr", 1'b1, 4'h0, 32'h8000_0010, 32'h1111_1111, 1'b0, w);
    issue(0, "w0_rd_unchg", 1'b0, 4'h0, 32'h8000_0010, 32'h0, 1'b0, w);
    issue(0, "w0_wr_top", 1'b1, 4'hF, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, w);
    issue(0, "w0_rd_top", 1'b0, 4'h0, 32'h8000_0FFC, 32'h0, 1'b0, w);
    idle(0); @(posedge clk); #1;
    issue(0, "w0_wr_b2b", 1'b1, 4'hF, 32'h8000_0020, 32'h1234_5678, 1'b0, w);
    issue(0, "w0_rd_b2b", 1'b0, 4'h0, 32'h8000_0020, 32'h0, 1'b0, w);
    chk("w0_rd_b2b_gnt_wait", w, 0);
    idle(0);

    // three wait states, request held continuously
    issue(1, "w3_wr", 1'b1, 4'hF, 32'h8000_0040, 32'hA5A5_0001, 1'b0, w);
    for (int n = 0; n < 4; n++) begin
      issue(1, $sformatf("w3_rd%0d", n), 1'b0, 4'h0, 32'h8000_0040, 32'h0, 1'b0, w);
      chk($sformatf("w3_rd%0d_gnt_wait", n), w, 3);
    end
    idle(1);

    // two wait states, reset while a write is pending
    issue(2, "w2_wr", 1'b1, 4'hF, 32'h8000_0080, 32'h1111_1111, 1'b0, w);
    issue(2, "w2_rd", 1'b0, 4'h0, 32'h8000_0080, 32'h0, 1'b0, w);
    issue(2, "w2_wr_drop", 1'b1, 4'hF, 32'h8000_0080, 32'h2222_2222, 1'b1, w);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("w2_drop_no_rvalid%0d", n), {31'd0, rvalid[2]}, 32'd0);
    end
    @(posedge clk); #1;
    issue(2, "w2_rd_after_rst", 1'b0, 4'h0, 32'h8000_0080, 32'h0, 1'b0, w);
    idle(2);

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
